shift_deserializer: RTL

//  Serial-in/parallel-out collector: receiver end of the load/shift register

---
 rtl/shift_deserializer.sv | 112 +++++++++++
 1 files changed

// File: rtl/shift_deserializer.sv
// Serial-in/parallel-out collector that reassembles Bits-wide words and hands them out on a valid/ready port.
// Define PARITY_CHECK_EN to add a trailing even-parity bit per frame and the parityErr output.
module shift_deserializer #(
  parameter int Bits = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            frameStart,
  input  logic            msbFirst,
  input  logic            bitValid,
  input  logic            serialIn,
  output logic [Bits-1:0] wordOut,
  output logic            wordValid,
  input  logic            wordReady,
  output logic            overrun,
  output logic            busy
`ifdef PARITY_CHECK_EN
  ,
  output logic            parityErr
`endif
);

  localparam int CntW = $clog2(Bits + 1);
`ifdef PARITY_CHECK_EN
  localparam int FrameLen  = Bits + 1;
  localparam bit HasParity = 1'b1;
`else
  localparam int FrameLen  = Bits;
  localparam bit HasParity = 1'b0;
`endif
  localparam logic [CntW-1:0] LastIdx = CntW'(FrameLen - 1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  logic [0:0]      state;
  logic [Bits-1:0] shiftReg;
  logic [CntW-1:0] count;
  logic            frameMsb;

  logic [Bits-1:0] seedReg;
  logic [Bits-1:0] shiftedReg;
  logic [Bits-1:0] newWord;
  logic            useMsb;
  logic            completing;
  logic            parityBitNow;
`ifdef PARITY_CHECK_EN
  logic            newParity;
`endif

  // A frameStart cycle shifts into a cleared register using the live msbFirst.
  always_comb begin
    seedReg      = frameStart ? '0 : shiftReg;
    useMsb       = frameStart ? msbFirst : frameMsb;
    shiftedReg   = useMsb ? {seedReg[Bits-2:0], serialIn}
                          : {serialIn, seedReg[Bits-1:1]};
    completing   = !frameStart && (state == COLLECT) && bitValid && (count == LastIdx);
    parityBitNow = HasParity && (count == LastIdx);
    newWord      = HasParity ? shiftReg : shiftedReg;
`ifdef PARITY_CHECK_EN
    newParity    = (^shiftReg) ^ serialIn;
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      shiftReg  <= '0;
      count     <= '0;
      frameMsb  <= 1'b0;
      wordOut   <= '0;
      wordValid <= 1'b0;
      overrun   <= 1'b0;
`ifdef PARITY_CHECK_EN
      parityErr <= 1'b0;
`endif
    end else begin
      if (frameStart) begin
        state    <= COLLECT;
        frameMsb <= msbFirst;
        shiftReg <= bitValid ? shiftedReg : '0;
        count    <= bitValid ? CntW'(1) : '0;
      end else if ((state == COLLECT) && bitValid) begin
        if (!parityBitNow) shiftReg <= shiftedReg;
        if (count == LastIdx) begin
          state <= IDLE;
          count <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end

      // A word finishing while the previous one is still unconsumed is lost.
      if (completing) begin
        if (!wordValid || wordReady) begin
          wordOut   <= newWord;
          wordValid <= 1'b1;
`ifdef PARITY_CHECK_EN
          parityErr <= newParity;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end else if (wordValid && wordReady) begin
        wordValid <= 1'b0;
      end
    end
  end

  assign busy = (state == COLLECT);

endmodule
